regfile_scoreboard: RTL

Parametrised architectural register file with an integrated per-register pending-write scoreboard for the ARM pipeline. It serves NUM_RD combinational read ports to the ID stage and accepts one write-back per cycle from WB. It counts in-flight writes per register so ID can detect RAW hazards without a separate hazard unit. Writes occur on the rising clock edge; reset is synchronous.

---
 rtl/regfile_scoreboard_pkg.sv | 12 +
 rtl/regfile_scoreboard_if.sv | 35 +++
 rtl/regfile_pend_cnt.sv | 37 +++
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file defaults for the ARM pipeline regfile/scoreboard slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_scoreboard_pkg;

  localparam int REGISTER_LEN        = 32;  // architectural register width
  localparam int REGFILE_ADDRESS_LEN = 4;   // register address width
  localparam int REGISTER_MEM_SIZE   = 15;  // stored registers R0..R14 (R15/PC lives elsewhere)
  localparam int REGFILE_PEND_W      = 2;   // pending-write counter width per register
  localparam int REGFILE_NUM_RD      = 3;   // read ports Rn, Rm, Rs

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of ID read ports, WB write-back and issue-tracking signals for the regfile.
// Latency: wires only.
// Backpressure: iss_full is the only stall signal, driven by the regfile.
// Modports: master = pipeline side (ID/WB), slave = regfile_scoreboard.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = REGISTER_LEN,
  parameter int ADDR_W = REGFILE_ADDRESS_LEN,
  parameter int NUM_RD = REGFILE_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_full;
  logic                     pending_any;
  logic                     wb_underflow;

  modport master (
    output rd_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    input  rd_data, rd_pending, iss_full, pending_any, wb_underflow
  );

  modport slave (
    input  rd_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    output rd_data, rd_pending, iss_full, pending_any, wb_underflow
  );

endinterface

// File: rtl/regfile_pend_cnt.sv
// Saturating up/down count of in-flight writes to one architectural register.
// Latency: count updates at the rising edge; full/underflow are combinational.
// Backpressure: full tells the parent to refuse further issues to this register.
// Ports: clk, rst (sync, active-high), inc (issue), dec (write-back hit),
//        cnt (current count), full (cnt at max), underflow (dec while cnt==0).
module regfile_pend_cnt #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              full,
  output logic              underflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic dec_eff;

  // A write-back with nothing outstanding still writes data upstream but must not wrap the count.
  assign dec_eff   = dec && (cnt != '0);
  assign underflow = dec && (cnt == '0);
  assign full      = (cnt == PEND_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec_eff) begin
      if (cnt != PEND_MAX) cnt <= cnt + 1'b1;
    end else if (dec_eff && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register pending-write counters for RAW detection in ID.
// Latency: reads combinational; writes and counter changes visible the cycle after the edge.
// Backpressure: iss_full (combinational) refuses an issue whose destination counter is saturated.
// Ports: clk, rst (sync, active-high); bus (regfile_scoreboard_if.slave): rd_addr/rd_data/rd_pending
//        read ports, wb_en/wb_addr/wb_data write-back, iss_en/iss_addr/iss_full issue tracking,
//        pending_any and sticky wb_underflow status.
// Option: define REGFILE_BYPASS_EN for same-cycle write-through from write-back to the read ports.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = REGISTER_LEN,
  parameter int ADDR_W = REGFILE_ADDRESS_LEN,
  parameter int DEPTH  = REGISTER_MEM_SIZE,
  parameter int NUM_RD = REGFILE_NUM_RD,
  parameter int PEND_W = REGFILE_PEND_W
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_scoreboard_if.slave   bus
);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [PEND_W-1:0]        cnt [DEPTH];
  logic [DEPTH-1:0]         cnt_full;
  logic [DEPTH-1:0]         inc;
  logic [DEPTH-1:0]         dec;
  logic [DEPTH-1:0]         uf;
  logic                     iss_full;
  logic                     pending_any;
  logic                     wb_underflow;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;

  // A write-back retiring on the same edge frees a slot, so a saturated register can still accept.
  // Out-of-range destinations never match any r and are therefore never full.
  always_comb begin
    iss_full = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      if (bus.iss_en && (bus.iss_addr == ADDR_W'(r)) && cnt_full[r] &&
          !(bus.wb_en && (bus.wb_addr == ADDR_W'(r))))
        iss_full = 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cnt
    assign inc[g] = bus.iss_en && (bus.iss_addr == ADDR_W'(g)) && !iss_full;
    assign dec[g] = bus.wb_en && (bus.wb_addr == ADDR_W'(g));

    regfile_pend_cnt #(
      .PEND_W (PEND_W)
    ) u_pend_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[g]),
      .dec       (dec[g]),
      .cnt       (cnt[g]),
      .full      (cnt_full[g]),
      .underflow (uf[g])
    );
  end

  // Reset seeds each register with its own index so a fresh file is self-identifying.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
    end else if (bus.wb_en) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (bus.wb_addr == ADDR_W'(r)) mem[r] <= bus.wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      wb_underflow <= 1'b0;
    else if (|uf) wb_underflow <= 1'b1;
  end

  always_comb begin
    pending_any = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      if (cnt[r] != '0) pending_any = 1'b1;
    end
  end

  // Addresses outside the stored range match no r and fall through to the zero defaults.
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (bus.rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          rd_data[k*DATA_W +: DATA_W] = mem[r];
          rd_pending[k]               = (cnt[r] != '0);
`ifdef REGFILE_BYPASS_EN
          // The retiring write supplies the data and no longer counts as outstanding.
          if (bus.wb_en && (bus.wb_addr == ADDR_W'(r))) begin
            rd_data[k*DATA_W +: DATA_W] = bus.wb_data;
            rd_pending[k]               = (cnt[r] > PEND_W'(1));
          end
`else
          // Without write-through ID sees the write one cycle after the edge.
`endif
        end
      end
    end
  end

  assign bus.rd_data      = rd_data;
  assign bus.rd_pending   = rd_pending;
  assign bus.iss_full     = iss_full;
  assign bus.pending_any  = pending_any;
  assign bus.wb_underflow = wb_underflow;

endmodule
